// File: rtl/etapa_ejecucion.sv
// MIPS execute stage with the EX/MEM pipeline register.
// Selects the ALU second operand and destination register, computes the ALU
// result and latches it with the store data and MEM/WB control bits.
// Optional feature macro: ETAPA_EJECUCION_OVERFLOW_EN enables signed ADD
// (1101) and SUB (1111) whose signed overflow suppresses the register write.
module etapa_ejecucion #(
  parameter int WIDTH_DATA_MEM        = 32,
  parameter int CANT_REGISTROS        = 32,
  parameter int CANT_BITS_ADDR        = 11,
  parameter int CANT_BITS_REGISTROS   = 32,
  parameter int CANT_BITS_ALU_CONTROL = 4
) (
  input  logic                                i_clock,
  input  logic                                i_soft_reset,
  input  logic                                i_enable_pipeline,
  input  logic [CANT_BITS_ADDR-1:0]           i_adder_pc,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_data_A,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_data_B,
  input  logic [CANT_BITS_REGISTROS-1:0]      i_extension_signo_constante,
  input  logic [$clog2(CANT_REGISTROS)-1:0]   i_reg_rs,
  input  logic [$clog2(CANT_REGISTROS)-1:0]   i_reg_rt,
  input  logic [$clog2(CANT_REGISTROS)-1:0]   i_reg_rd,
  input  logic                                i_RegDst,
  input  logic                                i_RegWrite,
  input  logic                                i_ALUSrc,
  input  logic                                i_MemRead,
  input  logic                                i_MemWrite,
  input  logic                                i_MemtoReg,
  input  logic [CANT_BITS_ALU_CONTROL-1:0]    i_ALUCtrl,
  output logic                                o_RegWrite,
  output logic                                o_MemRead,
  output logic                                o_MemWrite,
  output logic                                o_MemtoReg,
  output logic [WIDTH_DATA_MEM-1:0]           o_result,
  output logic [WIDTH_DATA_MEM-1:0]           o_data_write_to_mem,
  output logic [$clog2(CANT_REGISTROS)-1:0]   o_registro_destino,
  output logic                                o_led
);

  localparam int W  = CANT_BITS_REGISTROS;
  localparam int RW = $clog2(CANT_REGISTROS);

  logic [W-1:0]  op_b_s;
  logic [RW-1:0] dest_s;
  logic [W-1:0]  sum_s;
  logic [W-1:0]  diff_s;
  logic [W-1:0]  alu_s;
  logic          ovf_s;
  logic          unused_s;

  // rs is carried for future forwarding logic and intentionally unused here
  assign unused_s = ^i_reg_rs;

  // Operand, destination and adder/subtractor shared by several ALU codes
  always_comb begin
    op_b_s = i_ALUSrc ? i_extension_signo_constante : i_data_B;
    dest_s = i_RegDst ? i_reg_rd : i_reg_rt;
    sum_s  = i_data_A + op_b_s;
    diff_s = i_data_A - op_b_s;
  end

  // ALU operation select and signed-overflow detection
  always_comb begin
    alu_s = {W{1'b0}};
    ovf_s = 1'b0;
    case (i_ALUCtrl)
      4'b0000: alu_s = i_data_A & op_b_s;
      4'b0001: alu_s = i_data_A | op_b_s;
      4'b0010: alu_s = sum_s;
      4'b0011: alu_s = i_data_A ^ op_b_s;
      4'b0100: alu_s = ~(i_data_A | op_b_s);
      4'b0101: alu_s = diff_s;
      4'b0110: alu_s = {{(W-1){1'b0}}, (i_data_A < op_b_s)};
      4'b0111: alu_s = {{(W-1){1'b0}}, ($signed(i_data_A) < $signed(op_b_s))};
      4'b1000: alu_s = {op_b_s[15:0], 16'h0000};
      4'b1001: alu_s = op_b_s << i_data_A[4:0];
      4'b1010: alu_s = op_b_s >> i_data_A[4:0];
      4'b1011: alu_s = $signed(op_b_s) >>> i_data_A[4:0];
      4'b1100: alu_s = i_data_A;
      4'b1110: alu_s = {{(W-CANT_BITS_ADDR){1'b0}}, i_adder_pc};
`ifdef ETAPA_EJECUCION_OVERFLOW_EN
      4'b1101: begin
        alu_s = sum_s;
        ovf_s = (i_data_A[W-1] == op_b_s[W-1]) && (sum_s[W-1] != i_data_A[W-1]);
      end
      4'b1111: begin
        alu_s = diff_s;
        ovf_s = (i_data_A[W-1] != op_b_s[W-1]) && (diff_s[W-1] != i_data_A[W-1]);
      end
`else
      4'b1101: alu_s = sum_s;
      4'b1111: alu_s = diff_s;
`endif
      default: alu_s = {W{1'b0}};
    endcase
  end

  // EX/MEM pipeline register: async clear, loads only when the pipeline advances
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      o_RegWrite          <= 1'b0;
      o_MemRead           <= 1'b0;
      o_MemWrite          <= 1'b0;
      o_MemtoReg          <= 1'b0;
      o_result            <= {WIDTH_DATA_MEM{1'b0}};
      o_data_write_to_mem <= {WIDTH_DATA_MEM{1'b0}};
      o_registro_destino  <= {RW{1'b0}};
      o_led               <= 1'b0;
    end else if (i_enable_pipeline) begin
      o_RegWrite          <= i_RegWrite & ~ovf_s;
      o_MemRead           <= i_MemRead;
      o_MemWrite          <= i_MemWrite;
      o_MemtoReg          <= i_MemtoReg;
      o_result            <= alu_s;
      o_data_write_to_mem <= i_data_B;
      o_registro_destino  <= dest_s;
      o_led               <= (alu_s == {W{1'b0}});
    end else begin
      o_RegWrite          <= o_RegWrite;
      o_MemRead           <= o_MemRead;
      o_MemWrite          <= o_MemWrite;
      o_MemtoReg          <= o_MemtoReg;
      o_result            <= o_result;
      o_data_write_to_mem <= o_data_write_to_mem;
      o_registro_destino  <= o_registro_destino;
      o_led               <= o_led;
    end
  end

endmodule

// File: tb/tb_etapa_ejecucion.sv
// Directed self-checking bench for etapa_ejecucion.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_etapa_ejecucion;

  logic        i_clock = 1'b0;
  logic        i_soft_reset;
  logic        i_enable_pipeline;
  logic [10:0] i_adder_pc;
  logic [31:0] i_data_A;
  logic [31:0] i_data_B;
  logic [31:0] i_extension_signo_constante;
  logic [4:0]  i_reg_rs;
  logic [4:0]  i_reg_rt;
  logic [4:0]  i_reg_rd;
  logic        i_RegDst;
  logic        i_RegWrite;
  logic        i_ALUSrc;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic        i_MemtoReg;
  logic [3:0]  i_ALUCtrl;
  logic        o_RegWrite;
  logic        o_MemRead;
  logic        o_MemWrite;
  logic        o_MemtoReg;
  logic [31:0] o_result;
  logic [31:0] o_data_write_to_mem;
  logic [4:0]  o_registro_destino;
  logic        o_led;

  int n_checks = 0;
  int n_fail   = 0;

  etapa_ejecucion dut (
    .i_clock                     (i_clock),
    .i_soft_reset                (i_soft_reset),
    .i_enable_pipeline           (i_enable_pipeline),
    .i_adder_pc                  (i_adder_pc),
    .i_data_A                    (i_data_A),
    .i_data_B                    (i_data_B),
    .i_extension_signo_constante (i_extension_signo_constante),
    .i_reg_rs                    (i_reg_rs),
    .i_reg_rt                    (i_reg_rt),
    .i_reg_rd                    (i_reg_rd),
    .i_RegDst                    (i_RegDst),
    .i_RegWrite                  (i_RegWrite),
    .i_ALUSrc                    (i_ALUSrc),
    .i_MemRead                   (i_MemRead),
    .i_MemWrite                  (i_MemWrite),
    .i_MemtoReg                  (i_MemtoReg),
    .i_ALUCtrl                   (i_ALUCtrl),
    .o_RegWrite                  (o_RegWrite),
    .o_MemRead                   (o_MemRead),
    .o_MemWrite                  (o_MemWrite),
    .o_MemtoReg                  (o_MemtoReg),
    .o_result                    (o_result),
    .o_data_write_to_mem         (o_data_write_to_mem),
    .o_registro_destino          (o_registro_destino),
    .o_led                       (o_led)
  );

  // Free-running clock, 10 time-unit period
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".result"}, o_result, 32'h0);
    check({tag, ".data"},   o_data_write_to_mem, 32'h0);
    check({tag, ".dest"},   {27'd0, o_registro_destino}, 32'h0);
    check({tag, ".ctrl"},   {28'd0, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg}, 32'h0);
    check({tag, ".led"},    {31'd0, o_led}, 32'h0);
  endtask

  initial begin
    i_soft_reset = 1'b1;
    i_enable_pipeline = 1'b0;
    i_adder_pc = 11'd0;
    i_data_A = 32'd1;
    i_data_B = 32'd0;
    i_extension_signo_constante = 32'd0;
    i_reg_rs = 5'd1;
    i_reg_rt = 5'd0;
    i_reg_rd = 5'd0;
    i_RegDst = 1'b0;
    i_RegWrite = 1'b0;
    i_ALUSrc = 1'b0;
    i_MemRead = 1'b0;
    i_MemWrite = 1'b0;
    i_MemtoReg = 1'b0;
    i_ALUCtrl = 4'b0010;

    // Reset state, then hold with enable low
    step();
    check_all_zero("reset");
    i_soft_reset = 1'b0;
    step();
    check_all_zero("hold_en0");
    i_enable_pipeline = 1'b1;
    step();
    check("first_capture", o_result, 32'd1);
    check("first_led", {31'd0, o_led}, 32'd0);

    // ADDU register path and destination select
    i_data_B = 32'd2; i_reg_rt = 5'd2; i_reg_rd = 5'd3;
    i_MemWrite = 1'b1; i_MemtoReg = 1'b1;
    step();
    check("addu", o_result, 32'd3);
    check("dest_rt", {27'd0, o_registro_destino}, 32'd2);
    check("store_data", o_data_write_to_mem, 32'd2);
    check("memwr_memtoreg", {30'd0, o_MemWrite, o_MemtoReg}, 32'd3);
    i_RegDst = 1'b1;
    step();
    check("dest_rd", {27'd0, o_registro_destino}, 32'd3);

    // Immediate, LUI, LINK, SLTI
    i_MemWrite = 1'b0; i_MemtoReg = 1'b0;
    i_ALUSrc = 1'b1; i_extension_signo_constante = 32'd20;
    step();
    check("addiu", o_result, 32'd21);
    check("store_data_imm", o_data_write_to_mem, 32'd2);
    i_ALUCtrl = 4'b1000;
    step();
    check("lui", o_result, 32'h0014_0000);
    i_ALUCtrl = 4'b1110; i_adder_pc = 11'd5;
    step();
    check("link", o_result, 32'd5);
    i_ALUCtrl = 4'b0111;
    step();
    check("slti", o_result, 32'd1);

    // Signed vs unsigned compare, control bits arrive one cycle later
    i_ALUSrc = 1'b0; i_data_B = 32'hFFFF_FFFF;
    i_RegWrite = 1'b1; i_MemRead = 1'b1;
    check("ctrl_before_edge", {30'd0, o_RegWrite, o_MemRead}, 32'd0);
    step();
    check("slt_neg1", o_result, 32'd0);
    check("slt_led", {31'd0, o_led}, 32'd1);
    check("ctrl_after_edge", {30'd0, o_RegWrite, o_MemRead}, 32'd3);
    i_ALUCtrl = 4'b0110;
    step();
    check("sltu_neg1", o_result, 32'd1);
    check("sltu_led", {31'd0, o_led}, 32'd0);

    // Logic ops
    i_data_A = 32'hF0F0_1234; i_data_B = 32'h0FF0_FF00;
    i_ALUCtrl = 4'b0000; step(); check("and", o_result, 32'h00F0_1200);
    i_ALUCtrl = 4'b0001; step(); check("or",  o_result, 32'hFFF0_FF34);
    i_ALUCtrl = 4'b0011; step(); check("xor", o_result, 32'hFF00_ED34);
    i_ALUCtrl = 4'b0100; step(); check("nor", o_result, 32'h000F_00CB);

    // Wraparound subtract
    i_data_A = 32'd0; i_data_B = 32'd1; i_ALUCtrl = 4'b0101;
    step();
    check("subu_wrap", o_result, 32'hFFFF_FFFF);

    // Shifts use only A[4:0] (36 -> 4)
    i_data_A = 32'd36; i_data_B = 32'h0000_00F1; i_ALUCtrl = 4'b1001;
    step(); check("sllv", o_result, 32'h0000_0F10);
    i_data_B = 32'h8000_0000; i_ALUCtrl = 4'b1010;
    step(); check("srlv", o_result, 32'h0800_0000);
    i_ALUCtrl = 4'b1011;
    step(); check("srav", o_result, 32'hF800_0000);
    i_ALUCtrl = 4'b1100;
    step(); check("pass_a", o_result, 32'd36);

    // Signed add/sub overflow behaviour
    i_data_A = 32'h7FFF_FFFF; i_data_B = 32'd1; i_ALUCtrl = 4'b1101; i_RegWrite = 1'b1;
    step();
    check("add_ovf_result", o_result, 32'h8000_0000);
`ifdef ETAPA_EJECUCION_OVERFLOW_EN
    check("add_ovf_regwrite", {31'd0, o_RegWrite}, 32'd0);
`else
    check("add_ovf_regwrite", {31'd0, o_RegWrite}, 32'd1);
`endif
    i_data_A = 32'h8000_0000; i_ALUCtrl = 4'b1111;
    step();
    check("sub_ovf_result", o_result, 32'h7FFF_FFFF);
`ifdef ETAPA_EJECUCION_OVERFLOW_EN
    check("sub_ovf_regwrite", {31'd0, o_RegWrite}, 32'd0);
`else
    check("sub_ovf_regwrite", {31'd0, o_RegWrite}, 32'd1);
`endif
    i_data_A = 32'd5; i_data_B = 32'd6; i_ALUCtrl = 4'b1101;
    step();
    check("add_no_ovf", o_result, 32'd11);
    check("add_no_ovf_regwrite", {31'd0, o_RegWrite}, 32'd1);

    // Enable low holds despite changing inputs
    i_enable_pipeline = 1'b0; i_data_A = 32'd100; i_reg_rd = 5'd9;
    step();
    check("hold_result", o_result, 32'd11);
    check("hold_dest", {27'd0, o_registro_destino}, 32'd3);

    // Asynchronous reset mid-operation, dominating enable
    i_enable_pipeline = 1'b1;
    #1 i_soft_reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    check_all_zero("reset_over_enable");
    i_soft_reset = 1'b0;
    step();
    check("post_reset_capture", o_result, 32'd106);
    check("post_reset_dest", {27'd0, o_registro_destino}, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
